// File: rtl/tictac_pkg.sv
// Shared codes for the tic-tac-toe referee: outcomes, cell values,
// cell indices, FSM states and a board cell accessor.
package tictac_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [2:0] {
    IN_PROGRESS = 3'd0,
    P1_WIN      = 3'd1,
    P1_LOSE     = 3'd2,
    TIE         = 3'd3
  } outcome_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_e;

  localparam logic [3:0] A1 = 4'd1;
  localparam logic [3:0] A2 = 4'd2;
  localparam logic [3:0] A3 = 4'd3;
  localparam logic [3:0] B1 = 4'd4;
  localparam logic [3:0] B2 = 4'd5;
  localparam logic [3:0] B3 = 4'd6;
  localparam logic [3:0] C1 = 4'd7;
  localparam logic [3:0] C2 = 4'd8;
  localparam logic [3:0] C3 = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REJECT,
    S_WRITE,
    S_SCAN,
    S_RESOLVE
  } state_e;

  // Cell k (1..9) lives at bits [2k-1:2k-2]; others read as empty.
  function automatic logic [1:0] cell_at(
    input logic [17:0] b,
    input logic [3:0]  k
  );
    logic [1:0] r;
    r = EMPTY;
    for (int i = 1; i <= NUM_CELLS; i++)
      if (k == 4'(i)) r = b[2*i-2 +: 2];
    return r;
  endfunction

endpackage

// File: rtl/line_table.sv
// Winning-line table: line index 0..7 -> three cell indices.
// Order: rows A,B,C; columns 1,2,3; diagonals A1-B2-C3, A3-B2-C1.
module line_table
  import tictac_pkg::*;
(
  input  logic [2:0] idx,
  output logic [3:0] c0,
  output logic [3:0] c1,
  output logic [3:0] c2
);

  always_comb begin
    c0 = A1;
    c1 = A2;
    c2 = A3;
    unique case (idx)
      3'd0: begin c0 = A1; c1 = A2; c2 = A3; end
      3'd1: begin c0 = B1; c1 = B2; c2 = B3; end
      3'd2: begin c0 = C1; c1 = C2; c2 = C3; end
      3'd3: begin c0 = A1; c1 = B1; c2 = C1; end
      3'd4: begin c0 = A2; c1 = B2; c2 = C2; end
      3'd5: begin c0 = A3; c1 = B3; c2 = C3; end
      3'd6: begin c0 = A1; c1 = B2; c2 = C3; end
      3'd7: begin c0 = A3; c1 = B2; c2 = C1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/move_judge.sv
// Tic-tac-toe referee: validates and records moves, then scans lines.
// Ports: clk, rst (async low), clear, move_req, move[3:0], player[1:0]
//   -> busy, done, valid, outcome[2:0], move_count[3:0], board[17:0].
// Build option: EARLY_EXIT_EN ends the line scan at the first match.
module move_judge
  import tictac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        move_req,
  input  logic [3:0]  move,
  input  logic [1:0]  player,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [2:0]  outcome,
  output logic [3:0]  move_count,
  output logic [17:0] board
);

  state_e      state;
  state_e      nxt;
  logic [3:0]  mv;
  logic [1:0]  pl;
  logic [2:0]  line_idx;
  logic        win_flag;
  logic [3:0]  c0, c1, c2;
  logic        hit;
  logic        illegal;
  logic [17:0] board_wr;
  logic        busy_d;
  logic        done_d;
  logic        valid_d;
  logic [2:0]  outcome_d;

  line_table u_lines (
    .idx (line_idx),
    .c0  (c0),
    .c1  (c1),
    .c2  (c2)
  );

  assign hit = (cell_at(board, c0) == pl)
            && (cell_at(board, c1) == pl)
            && (cell_at(board, c2) == pl);

  assign illegal = (mv == 4'd0) || (mv > 4'd9)
                || (pl == 2'b00) || (pl == 2'b11)
                || (cell_at(board, mv) != EMPTY)
                || (outcome != IN_PROGRESS);

  always_comb begin
    board_wr = board;
    for (int i = 1; i <= NUM_CELLS; i++)
      if (mv == 4'(i)) board_wr[2*i-2 +: 2] = pl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= S_IDLE;
    else if (clear) state <= S_IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (move_req) nxt = S_LOOKUP;
      S_LOOKUP:  nxt = illegal ? S_REJECT : S_WRITE;
      S_REJECT:  nxt = S_IDLE;
      S_WRITE:   nxt = S_SCAN;
`ifdef EARLY_EXIT_EN
      S_SCAN:    if (hit || line_idx == 3'd7) nxt = S_RESOLVE;
`else
      S_SCAN:    if (line_idx == 3'd7) nxt = S_RESOLVE;
`endif
      S_RESOLVE: nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    busy_d  = (nxt == S_LOOKUP) || (nxt == S_WRITE)
           || (nxt == S_SCAN);
    done_d  = (nxt == S_REJECT) || (nxt == S_RESOLVE);
    valid_d = (nxt == S_RESOLVE);
    // The final scanned line is folded in here, not via win_flag.
    if (win_flag || hit)
      outcome_d = (pl == P1) ? P1_WIN : P1_LOSE;
    else if (move_count == 4'd9)
      outcome_d = TIE;
    else
      outcome_d = IN_PROGRESS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      outcome    <= IN_PROGRESS;
      move_count <= 4'd0;
      board      <= '0;
      mv         <= 4'd0;
      pl         <= 2'b00;
      line_idx   <= 3'd0;
      win_flag   <= 1'b0;
    end else if (clear) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      outcome    <= IN_PROGRESS;
      move_count <= 4'd0;
      board      <= '0;
      line_idx   <= 3'd0;
      win_flag   <= 1'b0;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      valid <= valid_d;
      if (state == S_IDLE && move_req) begin
        mv <= move;
        pl <= player;
      end
      if (state == S_WRITE) begin
        board      <= board_wr;
        move_count <= move_count + 4'd1;
        line_idx   <= 3'd0;
        win_flag   <= 1'b0;
      end
      if (state == S_SCAN) begin
        line_idx <= line_idx + 3'd1;
        if (hit) win_flag <= 1'b1;
        if (nxt == S_RESOLVE) outcome <= outcome_d;
      end
    end
  end

endmodule

// File: tb/tb_move_judge.sv
// Directed self-checking bench for move_judge.
// Honours EARLY_EXIT_EN for the winning-move latency.
module tb_move_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        move_req;
  logic [3:0]  move;
  logic [1:0]  player;
  logic        busy;
  logic        done;
  logic        valid;
  logic [2:0]  outcome;
  logic [3:0]  move_count;
  logic [17:0] board;

  int total = 0;
  int bad   = 0;

  move_judge dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .move_req   (move_req),
    .move       (move),
    .player     (player),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .outcome    (outcome),
    .move_count (move_count),
    .board      (board)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Request issued in cycle T; lat is the cycle offset of done.
  task automatic go(
    input  logic [3:0] m,
    input  logic [1:0] p,
    output int         lat,
    output logic       v
  );
    @(posedge clk); #1;
    move     = m;
    player   = p;
    move_req = 1'b1;
    @(posedge clk); #1;
    move_req = 1'b0;
    chk("busy_t1", 32'(busy), 32'd1);
    lat = 0;
    v   = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (done) begin
        lat = n;
        v   = valid;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int   lat;
    logic v;
    int   win_lat;
`ifdef EARLY_EXIT_EN
    win_lat = 4;
`else
    win_lat = 11;
`endif
    rst      = 1'b0;
    clear    = 1'b0;
    move_req = 1'b0;
    move     = 4'd0;
    player   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_board", 32'(board), 32'd0);
    chk("rst_count", 32'(move_count), 32'd0);
    chk("rst_outcome", 32'(outcome), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    rst = 1'b1;

    go(4'd5, 2'b01, lat, v);
    chk("first_lat", 32'(lat), 32'd11);
    chk("first_valid", 32'(v), 32'd1);
    chk("first_board", 32'(board), 32'h100);
    chk("first_count", 32'(move_count), 32'd1);
    chk("first_outcome", 32'(outcome), 32'd0);

    go(4'd5, 2'b10, lat, v);
    chk("occ_lat", 32'(lat), 32'd2);
    chk("occ_valid", 32'(v), 32'd0);
    chk("occ_board", 32'(board), 32'h100);
    chk("occ_count", 32'(move_count), 32'd1);

    go(4'd0, 2'b01, lat, v);
    chk("m0_lat", 32'(lat), 32'd2);
    chk("m0_valid", 32'(v), 32'd0);
    go(4'd12, 2'b10, lat, v);
    chk("m12_lat", 32'(lat), 32'd2);
    chk("m12_valid", 32'(v), 32'd0);
    go(4'd3, 2'b11, lat, v);
    chk("p11_lat", 32'(lat), 32'd2);
    chk("p11_valid", 32'(v), 32'd0);
    chk("rej_count", 32'(move_count), 32'd1);
    chk("rej_board", 32'(board), 32'h100);

    do_clear();
    chk("clr_board", 32'(board), 32'd0);
    chk("clr_count", 32'(move_count), 32'd0);

    go(4'd1, 2'b01, lat, v);
    go(4'd4, 2'b10, lat, v);
    go(4'd2, 2'b01, lat, v);
    go(4'd5, 2'b10, lat, v);
    chk("pre_win_outcome", 32'(outcome), 32'd0);
    go(4'd3, 2'b01, lat, v);
    chk("win_lat", 32'(lat), 32'(win_lat));
    chk("win_valid", 32'(v), 32'd1);
    chk("win_outcome", 32'(outcome), 32'd1);
    chk("win_count", 32'(move_count), 32'd5);
    chk("win_board", 32'(board), 32'h295);

    go(4'd9, 2'b10, lat, v);
    chk("lock_lat", 32'(lat), 32'd2);
    chk("lock_valid", 32'(v), 32'd0);
    chk("lock_outcome", 32'(outcome), 32'd1);
    chk("lock_board", 32'(board), 32'h295);

    do_clear();
    chk("clr2_outcome", 32'(outcome), 32'd0);
    go(4'd1, 2'b01, lat, v);
    go(4'd2, 2'b10, lat, v);
    go(4'd3, 2'b01, lat, v);
    go(4'd5, 2'b10, lat, v);
    go(4'd4, 2'b01, lat, v);
    go(4'd6, 2'b10, lat, v);
    go(4'd8, 2'b01, lat, v);
    go(4'd7, 2'b10, lat, v);
    go(4'd9, 2'b01, lat, v);
    chk("tie_valid", 32'(v), 32'd1);
    chk("tie_outcome", 32'(outcome), 32'd3);
    chk("tie_count", 32'(move_count), 32'd9);
    chk("tie_board", 32'(board), 32'h16A59);

    do_clear();
    go(4'd1, 2'b01, lat, v);
    go(4'd2, 2'b10, lat, v);
    go(4'd3, 2'b01, lat, v);
    go(4'd4, 2'b10, lat, v);
    go(4'd5, 2'b01, lat, v);
    go(4'd6, 2'b10, lat, v);
    go(4'd8, 2'b01, lat, v);
    go(4'd7, 2'b10, lat, v);
    chk("w9_pre_outcome", 32'(outcome), 32'd0);
    go(4'd9, 2'b01, lat, v);
    chk("w9_outcome", 32'(outcome), 32'd1);
    chk("w9_count", 32'(move_count), 32'd9);

    do_clear();
    go(4'd1, 2'b01, lat, v);
    go(4'd4, 2'b10, lat, v);
    go(4'd2, 2'b01, lat, v);
    go(4'd5, 2'b10, lat, v);
    go(4'd9, 2'b01, lat, v);
    go(4'd6, 2'b10, lat, v);
    chk("p2win_outcome", 32'(outcome), 32'd2);
    chk("p2win_valid", 32'(v), 32'd1);

    // clear sampled in cycle T+5 of an accepted move
    do_clear();
    @(posedge clk); #1;
    move     = 4'd5;
    player   = 2'b01;
    move_req = 1'b1;
    @(posedge clk); #1;
    move_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("abort_board", 32'(board), 32'd0);
    chk("abort_count", 32'(move_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    go(4'd5, 2'b01, lat, v);
    chk("after_clr_lat", 32'(lat), 32'd11);
    chk("after_clr_valid", 32'(v), 32'd1);
    chk("after_clr_board", 32'(board), 32'h100);

    // async reset in cycle T+6 (mid-scan)
    @(posedge clk); #1;
    move     = 4'd1;
    player   = 2'b10;
    move_req = 1'b1;
    @(posedge clk); #1;
    move_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("arst_board", 32'(board), 32'd0);
    chk("arst_count", 32'(move_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    go(4'd1, 2'b01, lat, v);
    chk("after_rst_lat", 32'(lat), 32'd11);
    chk("after_rst_valid", 32'(v), 32'd1);
    chk("after_rst_count", 32'(move_count), 32'd1);
    chk("after_rst_board", 32'(board), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
